// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: shared types and defaults for the hiscore RAM arbiter.
// Holds the arbiter state enum, the SETTLE/TIMEOUT defaults and a
// helper that sizes the shared settle/watchdog counter.
package hs_arb_pkg;

   // Arbiter states: CPU owns RAM (IDLE), CPU halt requested (REQ),
   // hiscore engine owns RAM (GRANT), one-cycle handback (REL).
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      GRANT = 2'd2,
      REL   = 2'd3
   } hs_arb_state_e;

   // Consecutive quiet paused cycles before the RAM is handed over.
   localparam int unsigned SETTLE_DEF  = 2;

   // Longest allowed grant when the watchdog is built in.
   localparam int unsigned TIMEOUT_DEF = 4096;

   // Bits needed to count from 0 up to limit-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned limit);
      int unsigned w;
      w = (limit < 2) ? 1 : $clog2(limit);
      return w;
   endfunction

endpackage

// File: rtl/hs_arb_counter.sv
// hs_arb_counter: small up-counter with synchronous clear and a
// terminal-count strobe. The arbiter shares one instance between the
// settle count (REQ) and the grant watchdog (GRANT); the two never run
// at the same time, so only the terminal value changes with the state.
module hs_arb_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk_sys,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] last,
   output logic         tc
);

   logic [W-1:0] count_q;

   // Count enabled cycles; clear wins over enable.
   always_ff @(posedge clk_sys) begin
      if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + W'(1);
      end
   end

   // Terminal count fires on the enabled cycle that completes the run,
   // i.e. the cycle in which the count would reach last+1.
   assign tc = enable & (count_q == last);

endmodule

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares a single-port RAM between a CPU and a hiscore
// engine. The engine asks for the RAM, the arbiter asks the pause system
// to halt the CPU, waits until the CPU has been quiet for SETTLE cycles,
// then switches the RAM mux to the engine until it lets go.
//
// Optional feature (macro HS_ARB_WATCHDOG_EN): a grant watchdog that
// ends any grant after TIMEOUT cycles and refuses a new request until
// the engine has dropped both intents once.
//
// Handshake: hs_grant is the only "go" for the engine. While hs_grant=1
// the RAM follows hs_address/hs_data_in/hs_write_enable in the same
// cycle; the engine keeps an intent high for as long as it needs the RAM
// and drops both intents to release it. Read data comes back one cycle
// after the address on both cpu_dout and hs_data_out (registered RAM).
module hs_ram_arbiter
   import hs_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SETTLE  = SETTLE_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_sys,
   input  logic              reset,
   // CPU side
   input  logic              cpu_cs,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic [DATA_W-1:0] cpu_dout,
   // pause system
   input  logic              paused,
   output logic              pause_req,
   // hiscore engine side
   input  logic              hs_read_intent,
   input  logic              hs_write_intent,
   input  logic [ADDR_W-1:0] hs_address,
   input  logic [DATA_W-1:0] hs_data_in,
   input  logic              hs_write_enable,
   output logic [DATA_W-1:0] hs_data_out,
   output logic              hs_grant,
   // single-port RAM
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout,
   // current arbiter state for observation
   output hs_arb_state_e     dbg_state
);

`ifdef HS_ARB_WATCHDOG_EN
   localparam int unsigned SETTLE_CW = cnt_width(SETTLE);
   localparam int unsigned WD_CW     = cnt_width(TIMEOUT);
   localparam int unsigned CNT_W     = (WD_CW > SETTLE_CW) ? WD_CW : SETTLE_CW;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
`else
   localparam int unsigned CNT_W     = cnt_width(SETTLE);
`endif
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

   hs_arb_state_e    state_q;
   hs_arb_state_e    state_next;
   logic             pause_req_q;
   logic             hs_grant_q;
   logic             abort_q;

   logic             any_intent;
   logic             quiet;
   logic             cnt_clear;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_last;
   logic             cnt_tc;
   logic             settle_done;
   logic             wd_expired;

   assign any_intent = hs_read_intent | hs_write_intent;

   // A settle cycle only counts when the CPU is halted and not touching RAM.
   assign quiet = paused & ~cpu_cs;

   // Counter control: settle run in REQ, watchdog run in GRANT. Any state
   // change restarts it so each REQ and each GRANT begins from zero.
   always_comb begin
      cnt_en    = 1'b0;
      cnt_last  = SETTLE_LAST;
      cnt_clear = reset | (state_next != state_q);
      case (state_q)
         REQ: begin
            cnt_en = quiet;
            if (!quiet) begin
               cnt_clear = 1'b1;
            end
         end
         GRANT: begin
`ifdef HS_ARB_WATCHDOG_EN
            cnt_en   = 1'b1;
            cnt_last = WD_LAST;
`else
            cnt_clear = 1'b1;
`endif
         end
         default: cnt_clear = 1'b1;
      endcase
   end

   hs_arb_counter #(
      .W (CNT_W)
   ) u_counter (
      .clk_sys (clk_sys),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .last    (cnt_last),
      .tc      (cnt_tc)
   );

   assign settle_done = cnt_tc & (state_q == REQ);

`ifdef HS_ARB_WATCHDOG_EN
   assign wd_expired = cnt_tc & (state_q == GRANT);

   // Sticky abort: set when the watchdog ends a grant, cleared only once
   // the engine has let go of both intents.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         abort_q <= 1'b0;
      end else if (wd_expired && any_intent) begin
         abort_q <= 1'b1;
      end else if (!any_intent) begin
         abort_q <= 1'b0;
      end
   end
`else
   assign wd_expired = 1'b0;
   assign abort_q    = 1'b0;
`endif

   // Next-state logic. In GRANT a released engine takes priority, then the
   // watchdog, then a CPU that left pause (which sends us back to settle).
   always_comb begin
      state_next = state_q;
      case (state_q)
         IDLE: begin
            if (any_intent && !abort_q) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (!any_intent) begin
               state_next = IDLE;
            end else if (settle_done) begin
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (!any_intent) begin
               state_next = REL;
            end else if (wd_expired) begin
               state_next = REL;
            end else if (!paused) begin
               state_next = REQ;
            end
         end
         REL: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register with pause_req/hs_grant registered alongside it.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         pause_req_q <= 1'b0;
         hs_grant_q  <= 1'b0;
      end else begin
         state_q     <= state_next;
         pause_req_q <= (state_next == REQ) || (state_next == GRANT);
         hs_grant_q  <= (state_next == GRANT);
      end
   end

   // RAM mux from the registered state. The engine drives the RAM only in
   // GRANT, and its writes are dropped in a cycle where the CPU left pause.
   // REL and reset both guarantee a write-free cycle.
   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_cs & cpu_we;
      case (state_q)
         GRANT: begin
            ram_addr = hs_address;
            ram_din  = hs_data_in;
            ram_we   = hs_write_enable & paused;
         end
         REL: begin
            ram_we = 1'b0;
         end
         default: begin
         end
      endcase
      if (reset) begin
         ram_we = 1'b0;
      end
   end

   // Read data goes to both masters straight from the RAM.
   assign cpu_dout    = ram_dout;
   assign hs_data_out = ram_dout;

   assign pause_req = pause_req_q;
   assign hs_grant  = hs_grant_q;
   assign dbg_state = state_q;

endmodule
